// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window controller.
package conv_pkg;

  // Window geometry: a 3x3 kernel, 9 taps per window.
  localparam int KERNEL      = 3;
  localparam int KERNEL_TAPS = KERNEL * KERNEL;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_READ = 3'd2,
    S_WAIT = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/conv_win_addr_gen.sv
// BRAM read-address generator: for window origin (r, c) and kernel row k,
// port j reads pixel (r+k)*IMG_W + c + j.
module conv_win_addr_gen
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int IMG_W      = 8
) (
  input  logic [ADDR_WIDTH-1:0]        r,
  input  logic [ADDR_WIDTH-1:0]        c,
  input  logic [1:0]                   k,
  output logic [ADDR_WIDTH*KERNEL-1:0] addrs
);

  logic [ADDR_WIDTH-1:0] base;

  // Row start plus column offset of the leftmost tap in kernel row k.
  assign base = (r + ADDR_WIDTH'(k)) * ADDR_WIDTH'(IMG_W) + c;

  for (genvar j = 0; j < KERNEL; j++) begin : g_port
    assign addrs[j*ADDR_WIDTH +: ADDR_WIDTH] = base + ADDR_WIDTH'(j);
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// 3x3 sliding-window controller: loads a raster image into an external BRAM,
// then reads it back one kernel row per cycle and streams every 3x3 window.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Pixel stream: the source holds i_px_data while i_px_valid is high
// and may drop valid at any time (gaps only stall). Window stream: o_win is
// held stable while o_win_valid is high and i_win_ready is low.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_PORTS  = 3,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  output logic                            o_busy,
  output logic                            o_done,
  input  logic                            i_px_valid,
  output logic                            o_px_ready,
  input  logic [RAM_WIDTH-1:0]            i_px_data,
  output logic                            o_bram_wr_en,
  output logic [ADDR_WIDTH-1:0]           o_bram_w_addrs,
  output logic [RAM_WIDTH-1:0]            o_bram_data,
  output logic [ADDR_WIDTH*RAM_PORTS-1:0] o_bram_r_addrs,
  input  logic [RAM_WIDTH*RAM_PORTS-1:0]  i_bram_data,
  output logic [RAM_WIDTH*KERNEL_TAPS-1:0] o_win,
  output logic                            o_win_valid,
  input  logic                            i_win_ready,
  output logic [2:0]                      o_dbg_state
);

  localparam int ROW_W = RAM_WIDTH * KERNEL;
  localparam logic [ADDR_WIDTH-1:0] LAST_PX  = ADDR_WIDTH'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_W - KERNEL);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(IMG_H - KERNEL);

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0]        px_cnt;
  logic [ADDR_WIDTH-1:0]        r;
  logic [ADDR_WIDTH-1:0]        c;
  logic [1:0]                   k;
  logic                         cap_en;
  logic [1:0]                   cap_k;
  logic [RAM_WIDTH*KERNEL_TAPS-1:0] win;
  logic [ADDR_WIDTH*KERNEL-1:0] rd_addrs;
  logic                         px_fire;
  logic                         win_fire;
  logic                         last_win;

  conv_win_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .IMG_W     (IMG_W)
  ) u_addr_gen (
    .r    (r),
    .c    (c),
    .k    (k),
    .addrs(rd_addrs)
  );

  assign px_fire  = i_px_valid & o_px_ready;
  assign win_fire = o_win_valid & i_win_ready;
  assign last_win = (r == LAST_ROW) && (c == LAST_COL);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    next_state     = state;
    o_busy         = (state != S_IDLE);
    o_px_ready     = (state == S_LOAD);
    o_win_valid    = (state == S_OUT);
    o_done         = (state == S_DONE);
    o_bram_r_addrs = '0;
    case (state)
      S_IDLE: if (i_start) next_state = S_LOAD;
      S_LOAD: if (px_fire && (px_cnt == LAST_PX)) next_state = S_READ;
      S_READ: begin
        o_bram_r_addrs = rd_addrs;
        if (k == 2'd2) next_state = S_WAIT;
      end
      S_WAIT: next_state = S_OUT;
      S_OUT:  if (win_fire) next_state = last_win ? S_DONE : S_READ;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign o_bram_wr_en   = px_fire;
  assign o_bram_w_addrs = px_cnt;
  assign o_bram_data    = i_px_data;
  assign o_win          = win;
  assign o_dbg_state    = state;

  // Pixel counter and window-origin / kernel-row counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      px_cnt <= '0;
      r      <= '0;
      c      <= '0;
      k      <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_start) px_cnt <= '0;
        S_LOAD: if (px_fire) begin
          px_cnt <= px_cnt + 1'b1;
          if (px_cnt == LAST_PX) begin
            r <= '0;
            c <= '0;
            k <= '0;
          end
        end
        S_READ: k <= (k == 2'd2) ? 2'd0 : k + 2'd1;
        S_OUT: if (win_fire) begin
          k <= '0;
          if (c == LAST_COL) begin
            c <= '0;
            r <= r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // BRAM data returns one cycle after the address; capture it into the row
  // slice of the kernel row that was issued on the previous cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cap_en <= 1'b0;
      cap_k  <= '0;
      win    <= '0;
    end else begin
      cap_en <= (state == S_READ);
      cap_k  <= k;
      if (cap_en) begin
        case (cap_k)
          2'd0:    win[0*ROW_W +: ROW_W] <= i_bram_data;
          2'd1:    win[1*ROW_W +: ROW_W] <= i_bram_data;
          default: win[2*ROW_W +: ROW_W] <= i_bram_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl on an 8x8 image whose pixel value is address+1,
// backed by a behavioural 3-read-port BRAM with 1-cycle read latency.
module tb_conv_window_ctrl;
  import conv_pkg::*;

  localparam int AW   = 6;
  localparam int RW   = 8;
  localparam int NP   = 3;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);
  localparam int WW   = RW * 9;

  localparam logic [WW-1:0] WIN_FIRST =
    {8'd19, 8'd18, 8'd17, 8'd11, 8'd10, 8'd9, 8'd3, 8'd2, 8'd1};
  localparam logic [WW-1:0] WIN_01 =
    {8'd20, 8'd19, 8'd18, 8'd12, 8'd11, 8'd10, 8'd4, 8'd3, 8'd2};
  localparam logic [WW-1:0] WIN_LAST =
    {8'd64, 8'd63, 8'd62, 8'd56, 8'd55, 8'd54, 8'd48, 8'd47, 8'd46};

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              px_valid;
  logic              px_ready;
  logic [RW-1:0]     px_data;
  logic              wr_en;
  logic [AW-1:0]     w_addr;
  logic [RW-1:0]     w_data;
  logic [AW*NP-1:0]  r_addrs;
  logic [RW*NP-1:0]  r_data;
  logic [WW-1:0]     win;
  logic              win_valid;
  logic              win_ready;
  logic [2:0]        dbg_state;

  logic [RW-1:0]     mem [0:NPIX-1];

  logic [WW-1:0]     exp_q[$];
  int                checks   = 0;
  int                failures = 0;
  int                n_acc    = 0;
  int                n_done   = 0;
  int                n_wr     = 0;
  int                exp_waddr = 0;
  bit                bad_addr = 1'b0;

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv_window_ctrl #(
    .ADDR_WIDTH(AW), .RAM_WIDTH(RW), .RAM_PORTS(NP), .IMG_W(W), .IMG_H(H)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .o_busy        (busy),
    .o_done        (done),
    .i_px_valid    (px_valid),
    .o_px_ready    (px_ready),
    .i_px_data     (px_data),
    .o_bram_wr_en  (wr_en),
    .o_bram_w_addrs(w_addr),
    .o_bram_data   (w_data),
    .o_bram_r_addrs(r_addrs),
    .i_bram_data   (r_data),
    .o_win         (win),
    .o_win_valid   (win_valid),
    .i_win_ready   (win_ready),
    .o_dbg_state   (dbg_state)
  );

  // Behavioural BRAM: one write port, three synchronous read ports.
  always @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
    for (int j = 0; j < NP; j++) r_data[j*RW +: RW] <= mem[r_addrs[j*AW +: AW]];
  end

  task automatic check(input string name, input logic [WW-1:0] act,
                       input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] win_model(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        w[(k*3+j)*RW +: RW] = RW'((r + k) * W + c + j + 1);
    return w;
  endfunction

  // Monitor: window scoreboard, write-port checks, done and address watch.
  always @(negedge clk) begin
    if (!rst) begin
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL win_unexpected actual=%0h required=none", win);
        end else begin
          check("win_data", win, exp_q.pop_front());
          if (n_acc == 0)        check("win_first", win, WIN_FIRST);
          if (n_acc == NWIN - 1) check("win_last", win, WIN_LAST);
        end
        n_acc++;
      end
      if (wr_en) begin
        check("wr_addr", WW'(w_addr), WW'(exp_waddr));
        check("wr_data", WW'(w_data), WW'(exp_waddr + 1));
        exp_waddr++;
        n_wr++;
      end
      if (done) n_done++;
      if ((dbg_state != 3'(S_READ)) && (r_addrs != '0)) bad_addr = 1'b1;
      for (int j = 0; j < NP; j++)
        if (int'(r_addrs[j*AW +: AW]) > NPIX - 1) bad_addr = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_frame();
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++)
        exp_q.push_back(win_model(r, c));
  endtask

  // Driver: stream one raster frame, optionally with gaps and stray starts.
  task automatic load_frame(input bit gaps, input bit poke);
    exp_waddr = 0;
    n_wr      = 0;
    n_acc     = 0;
    pulse_start();
    for (int a = 0; a < NPIX; a++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          px_valid = 1'b0;
          start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
          tick();
        end
      end
      px_valid = 1'b1;
      px_data  = RW'(a + 1);
      start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      check("px_ready", WW'(px_ready), WW'(1));
      tick();
    end
    px_valid = 1'b0;
    start    = 1'b0;
    check("wr_count", WW'(n_wr), WW'(NPIX));
    check("state_after_load", WW'(dbg_state), WW'(S_READ));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!win_valid && n < 50) begin
      tick();
      n++;
    end
    if (!win_valid) begin
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=o_win_valid", name);
    end
  endtask

  task automatic wait_done(input bit poke);
    int n;
    int d0;
    n  = 0;
    d0 = n_done;
    while (n_done == d0 && n < 2000) begin
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    if (n_done == d0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d cycles required=o_done", n);
    end
    tick();
    tick();
    check("idle_after_done", WW'(dbg_state), WW'(S_IDLE));
    check("win_count", WW'(n_acc), WW'(NWIN));
    check("exp_q_empty", WW'(exp_q.size()), WW'(0));
    check("done_pulses", WW'(n_done - d0), WW'(1));
  endtask

  initial begin
    int lat;
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    px_valid  = 1'b0;
    px_data   = '0;
    win_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ctrl", WW'({busy, done, win_valid, px_ready, wr_en, w_addr, r_addrs}), '0);
    check("rst_win", win, '0);
    check("rst_state", WW'(dbg_state), WW'(S_IDLE));

    // Frame 1: gapless load, ready always high.
    win_ready = 1'b1;
    push_frame();
    load_frame(1'b0, 1'b0);
    check("busy_in_read", WW'(busy), WW'(1));
    lat = 0;
    while (!win_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("win_latency", WW'(lat), WW'(4));
    wait_done(1'b0);

    // Frame 2: backpressure on window (0,1).
    win_ready = 1'b0;
    push_frame();
    load_frame(1'b0, 1'b0);
    wait_valid("valid_w00");
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
    wait_valid("valid_w01");
    for (int i = 0; i < 10; i++) begin
      check("hold_win", win, WIN_01);
      check("hold_ctrl", WW'({win_valid, r_addrs}), WW'({1'b1, {(AW*NP){1'b0}}}));
      tick();
    end
    win_ready = 1'b1;
    wait_done(1'b0);

    // Frame 3: random pixel gaps and stray start pulses while busy.
    push_frame();
    load_frame(1'b1, 1'b1);
    wait_done(1'b1);

    // Frame 4: reset during the READ of window 7, then a fresh frame.
    push_frame();
    load_frame(1'b0, 1'b0);
    n = 0;
    while (n_acc < 7 && n < 500) begin
      tick();
      n++;
    end
    n = 0;
    while (dbg_state != 3'(S_READ) && n < 20) begin
      tick();
      n++;
    end
    check("pre_rst_read", WW'(dbg_state), WW'(S_READ));
    exp_q.delete();
    rst = 1'b1;
    tick();
    check("mid_rst_ctrl", WW'({busy, done, win_valid, px_ready, wr_en, w_addr, r_addrs}), '0);
    check("mid_rst_win", win, '0);
    check("mid_rst_state", WW'(dbg_state), WW'(S_IDLE));
    rst = 1'b0;
    tick();
    check("idle_after_rst", WW'(dbg_state), WW'(S_IDLE));
    push_frame();
    load_frame(1'b0, 1'b0);
    wait_done(1'b0);

    check("addr_bounds", WW'(bad_addr), WW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, meaning the BRAM address width.
REQ-002 SHALL have parameter RAM_WIDTH, default 8, meaning the pixel width.
REQ-003 SHALL have parameter RAM_PORTS, default 3, meaning the number of BRAM read ports; only the value 3 is supported.
REQ-004 SHALL have parameter IMG_W, default 8, meaning the image width; IMG_H, default 8, meaning the image height; IMG_W*IMG_H <= 2**ADDR_WIDTH; IMG_W >= 3; IMG_H >= 3.
REQ-005 SHALL have port i_clk in 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port i_rst in 1; reset is synchronous and active-high.
REQ-007 SHALL have ports i_start in 1, o_busy out 1 and o_done out 1: start request, busy while not IDLE, and a 1-cycle done pulse.
REQ-008 SHALL have ports i_px_valid in 1, o_px_ready out 1 and i_px_data in RAM_WIDTH: the raster-order pixel load stream.
REQ-009 SHALL have ports o_bram_wr_en out 1, o_bram_w_addrs out ADDR_WIDTH and o_bram_data out RAM_WIDTH: the BRAM write port.
REQ-010 SHALL have ports o_bram_r_addrs out ADDR_WIDTH*RAM_PORTS and i_bram_data in RAM_WIDTH*RAM_PORTS: the BRAM read port; port j occupies slice j; read latency is 1 cycle.
REQ-011 SHALL have ports o_win out RAM_WIDTH*9, o_win_valid out 1 and i_win_ready in 1: the 3x3 window output stream.

Function
REQ-012 SHALL implement the states IDLE, LOAD, READ, WAIT, OUT and DONE.
REQ-013 In IDLE, i_start=1 SHALL go to LOAD and clear the pixel counter; i_start in any other state is ignored.
REQ-014 In LOAD, o_px_ready=1; o_bram_wr_en = i_px_valid & o_px_ready (combinational); o_bram_data = i_px_data; o_bram_w_addrs = pixel counter, which increments on each write.
REQ-015 After write IMG_W*IMG_H-1, the block SHALL go to READ with r=0, c=0, k=0; o_px_ready=0 outside LOAD; gaps in i_px_valid only stall.
REQ-016 In READ, port j address SHALL be (r+k)*IMG_W + c + j; k advances 0..2, one row per cycle, then the block goes to WAIT.
REQ-017 Row k data SHALL be captured one cycle after its issue into o_win[RAM_WIDTH*3*(k+1)-1 : RAM_WIDTH*3*k]; port j data goes to the j-th byte of that row slice, with the lowest byte being column c.
REQ-018 WAIT SHALL capture row 2 and go to OUT; o_win_valid is asserted only in OUT, so the window is presented 4 cycles after the first READ cycle.
REQ-019 In OUT, o_win SHALL stay stable while i_win_ready=0.
REQ-020 On o_win_valid & i_win_ready in OUT, the block SHALL advance c; at c=IMG_W-3, c wraps to 0 and r increments; it then returns to READ.
REQ-021 After the window at r=IMG_H-3, c=IMG_W-3 is accepted, the block SHALL go to DONE.
REQ-022 DONE SHALL assert o_done for one cycle and return to IDLE.
REQ-023 The block SHALL emit exactly (IMG_W-2)*(IMG_H-2) windows, i.e. 36 with the default parameters.
REQ-024 o_bram_r_addrs SHALL be 0 outside READ; no address exceeds IMG_W*IMG_H-1.

Reset
REQ-025 When i_rst=1, the next edge SHALL set the state to IDLE and zero all counters, o_win, o_win_valid, o_done, o_busy, o_px_ready, o_bram_wr_en, o_bram_w_addrs and o_bram_r_addrs.
REQ-026 Reset mid-operation SHALL abandon the frame; BRAM contents are not cleared; a new i_start begins a fresh LOAD.
REQ-027 Reset SHALL take priority over i_start and the handshakes in the same cycle.

Structure
REQ-028 The state encoding and the 3x3 kernel constant SHALL live in shared package conv_pkg.
REQ-029 Read-address generation SHALL be in one sub-module conv_win_addr_gen (inputs r, c, k; output packed addresses).
REQ-030 The block SHALL connect to the existing bram module port-for-port; it does not instantiate bram.

Verification (8x8 image, pixel value = address+1, connected to bram)
REQ-031 Stream 64 pixels with no gaps -> o_bram_wr_en high for 64 cycles, addresses 0..63, then READ.
REQ-032 First window -> row0 = {3,2,1}, row1 = {11,10,9}, row2 = {19,18,17}, with o_win_valid 4 cycles after the first READ cycle.
REQ-033 i_win_ready held at 1 -> 36 windows; last window rows {48,47,46}, {56,55,54}, {64,63,62}; single o_done pulse; then IDLE.
REQ-034 i_win_ready low for 10 cycles on window (0,1) -> o_win stable at {4,3,2}, {12,11,10}, {20,19,18}; no extra reads are issued.
REQ-035 Random i_px_valid gaps, plus i_start pulses while busy -> identical window sequence and no restart.
REQ-036 i_rst asserted during READ of window 7 -> all outputs zero next cycle; IDLE; a following i_start plus reload yields a correct first window.
